accumulator_ctrl: RTL and testbench

ACCUMULATOR_CTRL -- requirements
Module: accumulator_ctrl

---
 rtl/accumulator_ctrl.sv | 152 +++++++++++++++
 tb/tb_accumulator_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_ctrl.sv
// Sequencer for a tiled accumulator bank: fills rows with partial sums, accumulates
// the remaining K-tiles on top, then drains each result row to downstream logic.
module accumulator_ctrl #(
    parameter int ADDR_BITWIDTH = 4,
    parameter int TILE_BITWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [TILE_BITWIDTH-1:0] num_tiles,
    input  logic [ADDR_BITWIDTH:0]   num_rows,
    input  logic                     sum_valid,
    input  logic                     drain_ready,
    output logic                     wrt_en,
    output logic                     acc_logic,
    output logic [ADDR_BITWIDTH-1:0] acc_addr,
    output logic                     drain_valid,
    output logic [ADDR_BITWIDTH-1:0] drain_addr,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_ACCUM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_BITWIDTH:0]   Depth   = {1'b1, {ADDR_BITWIDTH{1'b0}}};
    localparam logic [ADDR_BITWIDTH:0]   RowsOne = (ADDR_BITWIDTH+1)'(1);
    localparam logic [ADDR_BITWIDTH-1:0] AddrOne = ADDR_BITWIDTH'(1);
    localparam logic [TILE_BITWIDTH-1:0] TileOne = TILE_BITWIDTH'(1);

    state_t                   state_q, state_d;
    logic [ADDR_BITWIDTH-1:0] rowCnt_q, rowCnt_d;
    logic [ADDR_BITWIDTH-1:0] drainCnt_q, drainCnt_d;
    logic [TILE_BITWIDTH-1:0] tileCnt_q, tileCnt_d;
    logic [TILE_BITWIDTH-1:0] numTiles_q, numTiles_d;
    logic [ADDR_BITWIDTH:0]   numRows_q, numRows_d;

    logic rowLast;
    logic drainLast;
    logic tileLast;

    // Terminal compares are one bit wider than the address so a full bank does not alias to zero.
    assign rowLast   = ({1'b0, rowCnt_q} == (numRows_q - RowsOne));
    assign drainLast = ({1'b0, drainCnt_q} == (numRows_q - RowsOne));
    assign tileLast  = (tileCnt_q == (numTiles_q - TileOne));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            rowCnt_q   <= '0;
            drainCnt_q <= '0;
            tileCnt_q  <= '0;
            numTiles_q <= '0;
            numRows_q  <= '0;
        end else begin
            state_q    <= state_d;
            rowCnt_q   <= rowCnt_d;
            drainCnt_q <= drainCnt_d;
            tileCnt_q  <= tileCnt_d;
            numTiles_q <= numTiles_d;
            numRows_q  <= numRows_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rowCnt_d    = rowCnt_q;
        drainCnt_d  = drainCnt_q;
        tileCnt_d   = tileCnt_q;
        numTiles_d  = numTiles_q;
        numRows_d   = numRows_q;
        wrt_en      = 1'b0;
        acc_logic   = 1'b0;
        drain_valid = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        acc_addr    = rowCnt_q;
        drain_addr  = drainCnt_q;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d    = S_FILL;
                    rowCnt_d   = '0;
                    tileCnt_d  = '0;
                    drainCnt_d = '0;
                    numTiles_d = (num_tiles == '0) ? TileOne : num_tiles;
                    if (num_rows == '0) begin
                        numRows_d = RowsOne;
                    end else if (num_rows > Depth) begin
                        numRows_d = Depth;
                    end else begin
                        numRows_d = num_rows;
                    end
                end
            end
            S_FILL, S_ACCUM: begin
                wrt_en    = sum_valid;
                acc_logic = (state_q == S_ACCUM);
                if (sum_valid) begin
                    if (rowLast) begin
                        rowCnt_d  = '0;
                        tileCnt_d = tileCnt_q + TileOne;
                        if (tileLast) begin
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_ACCUM;
                        end
                    end else begin
                        rowCnt_d = rowCnt_q + AddrOne;
                    end
                end
            end
            S_DRAIN: begin
                drain_valid = 1'b1;
                if (drain_ready) begin
                    if (drainLast) begin
                        drainCnt_d = '0;
                        state_d    = S_DONE;
                    end else begin
                        drainCnt_d = drainCnt_q + AddrOne;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs read as idle while reset is held, before the state register has cleared.
        if (reset) begin
            wrt_en      = 1'b0;
            acc_logic   = 1'b0;
            drain_valid = 1'b0;
            busy        = 1'b0;
            done        = 1'b0;
            acc_addr    = '0;
            drain_addr  = '0;
        end
    end

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Randomized scoreboard bench for accumulator_ctrl: a job-level model predicts every
// write, drain beat and done pulse, and a negedge monitor pops and compares them.
module tb_accumulator_ctrl;

    localparam int A = 4;
    localparam int T = 8;

    typedef struct {
        int kind;
        int addr;
        int acc;
    } ev_t;

    localparam int EvWrite = 0;
    localparam int EvDrain = 1;
    localparam int EvDone  = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [T-1:0] num_tiles = '0;
    logic [A:0]   num_rows = '0;
    logic         sum_valid = 1'b0;
    logic         drain_ready = 1'b0;
    logic         wrt_en;
    logic         acc_logic;
    logic [A-1:0] acc_addr;
    logic         drain_valid;
    logic [A-1:0] drain_addr;
    logic         busy;
    logic         done;

    ev_t expQ[$];
    int  tests = 0;
    int  fails = 0;
    int  doneCount = 0;
    int  sumMode = 0;
    int  validPct = 70;
    int  readyPct = 100;
    bit  directMode = 1'b0;
    bit  stallPrev = 1'b0;
    int  stallAddr = 0;
    bit  donePrev = 1'b0;
    bit  toggleBit = 1'b0;

    accumulator_ctrl #(.ADDR_BITWIDTH(A), .TILE_BITWIDTH(T)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .num_tiles(num_tiles),
        .num_rows(num_rows),
        .sum_valid(sum_valid),
        .drain_ready(drain_ready),
        .wrt_en(wrt_en),
        .acc_logic(acc_logic),
        .acc_addr(acc_addr),
        .drain_valid(drain_valid),
        .drain_addr(drain_addr),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int effRows(input int r);
        if (r == 0) return 1;
        if (r > (1 << A)) return 1 << A;
        return r;
    endfunction

    // Reference job: every tile writes every row (first tile overwrites), then every row drains once.
    task automatic pushJob(input int tiles, input int rows);
        int nt;
        int nr;
        nt = (tiles == 0) ? 1 : tiles;
        nr = effRows(rows);
        for (int t = 0; t < nt; t++)
            for (int r = 0; r < nr; r++)
                expQ.push_back('{EvWrite, r, (t > 0) ? 1 : 0});
        for (int r = 0; r < nr; r++)
            expQ.push_back('{EvDrain, r, 0});
        expQ.push_back('{EvDone, 0, 0});
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_wrt_en"}, int'(wrt_en), 0);
        checkOutput({tag, "_acc_logic"}, int'(acc_logic), 0);
        checkOutput({tag, "_acc_addr"}, int'(acc_addr), 0);
        checkOutput({tag, "_drain_valid"}, int'(drain_valid), 0);
        checkOutput({tag, "_drain_addr"}, int'(drain_addr), 0);
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_done"}, int'(done), 0);
    endtask

    // Drives sum_valid / drain_ready each cycle unless a directed test owns them.
    always @(posedge clk) begin
        #1;
        if (!directMode) begin
            toggleBit = ~toggleBit;
            case (sumMode)
                1:       sum_valid = 1'b1;
                2:       sum_valid = toggleBit;
                default: sum_valid = ($urandom_range(0, 99) < validPct);
            endcase
            drain_ready = ($urandom_range(0, 99) < readyPct);
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (reset) begin
            stallPrev = 1'b0;
            donePrev  = 1'b0;
        end else begin
            if (stallPrev) begin
                checkOutput("drain_hold_valid", int'(drain_valid), 1);
                checkOutput("drain_hold_addr", int'(drain_addr), stallAddr);
            end
            if (donePrev) checkOutput("busy_after_done", int'(busy), 0);
            if (wrt_en || drain_valid || done) checkOutput("busy_active", int'(busy), 1);
            if (wrt_en) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write_addr", int'(acc_addr), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("write_kind", EvWrite, e.kind);
                    if (e.kind == EvWrite) begin
                        checkOutput("acc_addr", int'(acc_addr), e.addr);
                        checkOutput("acc_logic", int'(acc_logic), e.acc);
                    end
                end
            end
            if (drain_valid && drain_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_drain_addr", int'(drain_addr), -1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("drain_kind", EvDrain, e.kind);
                    if (e.kind == EvDrain) checkOutput("drain_addr", int'(drain_addr), e.addr);
                end
            end
            if (done) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("done_kind", EvDone, e.kind);
                end
            end
            stallPrev = drain_valid && !drain_ready;
            stallAddr = int'(drain_addr);
            donePrev  = done;
        end
    end

    // Runs one job to completion while throwing ignored start pulses at the busy controller.
    task automatic applyStimulus(input int tiles, input int rows, input int mode, input int vPct, input int rPct);
        int startDone;
        int cycles;
        sumMode  = mode;
        validPct = vPct;
        readyPct = rPct;
        pushJob(tiles, rows);
        startDone = doneCount;
        @(posedge clk); #1;
        start     = 1'b1;
        num_tiles = T'(tiles);
        num_rows  = (A+1)'(rows);
        @(posedge clk); #1;
        cycles = 0;
        while (doneCount == startDone && cycles < 5000) begin
            start     = $urandom_range(0, 1) == 1;
            num_tiles = T'($urandom);
            num_rows  = (A+1)'($urandom);
            @(posedge clk); #1;
            cycles++;
        end
        start = 1'b0;
        if (cycles >= 5000) checkOutput("job_timeout_cycles", cycles, 0);
        checkOutput("job_queue_drained", expQ.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkIdleOutputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        checkIdleOutputs("post_reset");

        applyStimulus(1, 4, 1, 100, 100);
        applyStimulus(3, 2, 1, 100, 100);
        applyStimulus(2, 16, 2, 100, 100);
        applyStimulus(1, 8, 1, 100, 15);
        applyStimulus(0, 0, 1, 100, 100);
        applyStimulus(2, 31, 0, 60, 50);

        // Abort in ACCUM at row 1 of tile 1, then restart cleanly.
        directMode = 1'b1;
        sum_valid  = 1'b0;
        drain_ready = 1'b1;
        pushJob(3, 2);
        @(posedge clk); #1;
        start     = 1'b1;
        num_tiles = T'(3);
        num_rows  = (A+1)'(2);
        @(posedge clk); #1;
        start     = 1'b0;
        sum_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        sum_valid = 1'b0;
        reset     = 1'b1;
        expQ.delete();
        checkOutput("abort_doneCount_before", doneCount, 6);
        @(posedge clk); #1;
        reset = 1'b0;
        checkIdleOutputs("abort");
        @(posedge clk); #1;
        checkIdleOutputs("abort_idle");
        directMode = 1'b0;
        applyStimulus(1, 5, 1, 100, 100);

        for (int j = 0; j < 15; j++) begin
            applyStimulus($urandom_range(0, 5), $urandom_range(0, 31), 0,
                          $urandom_range(30, 100), $urandom_range(30, 100));
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("final_queue_empty", expQ.size(), 0);
        checkOutput("final_busy", int'(busy), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
